// File: rtl/button_debounce_if.sv
// Button debounce port bundle: raw pin in, clean level and press-class pulses out.
// Latency: none (wires only).
// Backpressure: none; all signals are levels or single-cycle pulses.
//
// Ports:
//   btn_raw     - asynchronous, bouncing push-button pin (polarity set by the block)
//   btn_n       - debounced level, 0 = pressed
//   short_press - one-cycle pulse on debounced release of a short press
//   long_press  - one-cycle pulse when a debounced hold reaches the long threshold
interface button_debounce_if;
   logic btn_raw;
   logic btn_n;
   logic short_press;
   logic long_press;

   // Driver of the raw pin / consumer of the classified outputs.
   modport master (
      output btn_raw,
      input  btn_n,
      input  short_press,
      input  long_press
   );

   // The debouncer itself.
   modport slave (
      input  btn_raw,
      output btn_n,
      output short_press,
      output long_press
   );
endinterface

// File: rtl/button_debounce.sv
// Debounces a raw push-button and classifies each press as short or long.
// Latency: btn_n follows a stable input after DEBOUNCE_CYCLES+2 edges; all outputs registered.
// Backpressure: none; pulses are fire-and-forget single cycles.
//
// Ports:
//   clk    - system clock, rising edge
//   reset  - synchronous, active-high, highest priority
//   btn_if - slave modport: btn_raw in; btn_n, short_press, long_press out
module button_debounce #(
   parameter int DEBOUNCE_CYCLES   = 200000,
   parameter int LONG_PRESS_CYCLES = 15000000,
   parameter bit ACTIVE_LOW        = 1'b1
) (
   input  logic               clk,
   input  logic               reset,
   button_debounce_if.slave   btn_if
);

   localparam int DEB_W  = (DEBOUNCE_CYCLES   > 2) ? $clog2(DEBOUNCE_CYCLES)   : 1;
   localparam int HOLD_W = (LONG_PRESS_CYCLES > 2) ? $clog2(LONG_PRESS_CYCLES) : 1;

   localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);

   // Raw pin level that means "not pressed"; synchronizer resets to it so a
   // reset never manufactures a press.
   localparam logic RELEASED_LVL = ACTIVE_LOW;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DEB_PRESS,
      ST_HELD,
      ST_DEB_RELEASE
   } state_t;

   state_t            state_q,       state_d;
   logic              sync1_q,       sync1_d;
   logic              sync2_q,       sync2_d;
   logic [DEB_W-1:0]  deb_cnt_q,     deb_cnt_d;
   logic [HOLD_W-1:0] hold_cnt_q,    hold_cnt_d;
   logic              long_done_q,   long_done_d;
   logic              btn_n_q,       btn_n_d;
   logic              short_press_q, short_press_d;
   logic              long_press_q,  long_press_d;

   logic              pressed;

   // FSM only ever looks at the second synchronizer stage.
   assign pressed = (sync2_q != RELEASED_LVL);

   always_comb begin
      sync1_d       = btn_if.btn_raw;
      sync2_d       = sync1_q;
      state_d       = state_q;
      deb_cnt_d     = deb_cnt_q;
      hold_cnt_d    = hold_cnt_q;
      long_done_d   = long_done_q;
      btn_n_d       = btn_n_q;
      short_press_d = 1'b0;
      long_press_d  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            btn_n_d = 1'b1;
            if (pressed) begin
               state_d     = ST_DEB_PRESS;
               deb_cnt_d   = '0;
               long_done_d = 1'b0;
            end
         end

         ST_DEB_PRESS: begin
            if (!pressed) begin
               state_d = ST_IDLE;
            end else if (deb_cnt_q == DEB_LAST) begin
               state_d    = ST_HELD;
               btn_n_d    = 1'b0;
               hold_cnt_d = '0;
            end else begin
               deb_cnt_d = deb_cnt_q + DEB_W'(1);
            end
         end

         ST_HELD: begin
            if (!pressed) begin
               state_d   = ST_DEB_RELEASE;
               deb_cnt_d = '0;
            end else if (hold_cnt_q == HOLD_LAST) begin
               // Counter sits at its last value for the rest of the hold, so
               // long_done keeps the pulse to exactly one per press.
               if (!long_done_q) begin
                  long_press_d = 1'b1;
                  long_done_d  = 1'b1;
               end
            end else begin
               hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            end
         end

         ST_DEB_RELEASE: begin
            // hold_cnt is left untouched here so a rejected release bounce
            // only delays the long-press threshold.
            if (pressed) begin
               state_d = ST_HELD;
            end else if (deb_cnt_q == DEB_LAST) begin
               state_d       = ST_IDLE;
               btn_n_d       = 1'b1;
               short_press_d = !long_done_q;
            end else begin
               deb_cnt_d = deb_cnt_q + DEB_W'(1);
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q       <= RELEASED_LVL;
         sync2_q       <= RELEASED_LVL;
         state_q       <= ST_IDLE;
         deb_cnt_q     <= '0;
         hold_cnt_q    <= '0;
         long_done_q   <= 1'b0;
         btn_n_q       <= 1'b1;
         short_press_q <= 1'b0;
         long_press_q  <= 1'b0;
      end else begin
         sync1_q       <= sync1_d;
         sync2_q       <= sync2_d;
         state_q       <= state_d;
         deb_cnt_q     <= deb_cnt_d;
         hold_cnt_q    <= hold_cnt_d;
         long_done_q   <= long_done_d;
         btn_n_q       <= btn_n_d;
         short_press_q <= short_press_d;
         long_press_q  <= long_press_d;
      end
   end

   assign btn_if.btn_n       = btn_n_q;
   assign btn_if.short_press = short_press_q;
   assign btn_if.long_press  = long_press_q;

endmodule

// File: doc/button_debounce.md
# button_debounce

Debounces the raw FPGA push-button and classifies each press as short or long. It sits directly upstream of the power-on/button reset generator. Its `btn_n` output is a clean, low-active level that drives that block's button input. Its `short_press` and `long_press` pulses are available to soft-reset and menu logic. Everything runs on the 10 MHz board clock.

## Interface
- `DEBOUNCE_CYCLES`, default 200000 (20 ms at 10 MHz). Number of cycles the input must be stable to be accepted. Must be ≥ 2.
- `LONG_PRESS_CYCLES`, default 15000000 (1.5 s). Debounced hold time that qualifies a press as long. Must be ≥ 2.
- `ACTIVE_LOW`, default 1. Polarity of `btn_raw`: 1 means pressed = 0; 0 means pressed = 1.
- `clk`  in  1  10 MHz system clock; all logic on its rising edge.
- `reset`  in  1  Reset, synchronous and active-high.
- `btn_raw`  in  1  Asynchronous, bouncing button pin.
- `btn_n`  out  1  Debounced level, low-active (0 = pressed), independent of `ACTIVE_LOW`.
- `short_press`  out  1  One-cycle pulse on debounced release if no long press occurred.
- `long_press`  out  1  One-cycle pulse when the debounced hold reaches `LONG_PRESS_CYCLES`.

## Operation
- **Synchronizer.**
  - Two-flop synchronizer on `btn_raw`; it is normalised to `pressed` (1 = pressed) according to `ACTIVE_LOW`.
  - Both flops reset to the released level.
  - The FSM only ever sees the second flop.
- **FSM states:** IDLE, DEB_PRESS, HELD, DEB_RELEASE. `deb_cnt` and `hold_cnt` are sized with `$clog2` of their parameter.
- **IDLE**
  - `btn_n`=1.
  - `pressed` → DEB_PRESS, `deb_cnt`←0, `long_done`←0.
- **DEB_PRESS**
  - `!pressed` → IDLE (bounce rejected, no pulse).
  - Else if `deb_cnt`==`DEBOUNCE_CYCLES`-1 → HELD, `btn_n`←0, `hold_cnt`←0.
  - Else `deb_cnt`++.
- **HELD**
  - `!pressed` → DEB_RELEASE, `deb_cnt`←0.
  - Else if `hold_cnt`==`LONG_PRESS_CYCLES`-1 and `!long_done` → `long_press`←1 for one cycle, `long_done`←1.
  - Else `hold_cnt`++, saturating at `LONG_PRESS_CYCLES`-1.
- **DEB_RELEASE**
  - `hold_cnt` is frozen.
  - `pressed` → HELD (release bounce rejected, `hold_cnt` resumes, no pulse).
  - Else if `deb_cnt`==`DEBOUNCE_CYCLES`-1 → IDLE, `btn_n`←1, and `short_press`←1 for one cycle iff `!long_done`.
  - Else `deb_cnt`++.
- **Pulse exclusivity:** at most one pulse per press. `long_press` and `short_press` are never high in the same cycle.
- **Registered outputs:** all three outputs are registered; no combinational path from `btn_raw`.
- **Reset.**
  - Reset takes priority over everything.
  - Next edge: state=IDLE, counters=0, `long_done`=0, `btn_n`=1, `short_press`=0, `long_press`=0.
  - A pulse in flight is dropped.
  - A button still held when reset deasserts is treated as a new press with full debounce.

## Timing
- **Press latency.** Edge k is the first edge at which `btn_raw` samples the pressed level, stable thereafter. `btn_n` is 0 after edge k+`DEBOUNCE_CYCLES`+2: two synchronizer edges, one IDLE→DEB_PRESS edge, then `DEBOUNCE_CYCLES`-1 counting edges.
- **Release latency.** Identical: `btn_n` returns to 1 after edge r+`DEBOUNCE_CYCLES`+2, where r is the first edge sampling released. `short_press` is high in that same cycle.
- **Long press.** `long_press` is high in the cycle after edge h+`LONG_PRESS_CYCLES`, where h is the edge that drove `btn_n` to 0, provided there is no release bounce in between. Release-bounce cycles spent in DEB_RELEASE add to this delay.
- **Bounce rejection.** Any pressed/released run shorter than `DEBOUNCE_CYCLES`+1 synchronized cycles causes no output change.
- **Long hold.** Holding past `LONG_PRESS_CYCLES` produces no further pulses; `hold_cnt` saturates without wrapping.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `LONG_PRESS_CYCLES`=20, `ACTIVE_LOW`=1 (except the last), and `reset` high for edges 0–1.
- **Clean long press.** `btn_raw`=0 sampled from edge 10, held through edge 49, then 1 → `btn_n`=0 after edge 16; `long_press`=1 only after edge 36; `btn_n`=1 after edge 56; `short_press` never 1.
- **Short press.** `btn_raw`=0 for edges 10–19, 1 from edge 20 → `btn_n` 0 after edge 16, 1 after edge 26; `short_press`=1 only after edge 26; `long_press` never 1.
- **Press bounce.** `btn_raw` toggles every 2 cycles from edge 10 to 30, then stays 1 → `btn_n` stays 1; both pulses stay 0.
- **Release bounce.** In HELD, `btn_raw`=1 for 2 cycles, then 0 again → `btn_n` stays 0, no `short_press`; `long_press` is still issued, delayed by the DEB_RELEASE cycles.
- **Reset mid-press.** In HELD with `btn_raw`=0, `reset`=1 for one edge r → after edge r, `btn_n`=1 and pulses are 0; `btn_n`=0 again after edge r+7.
- **Polarity.** With `ACTIVE_LOW`=0, repeat the short-press scenario with inverted `btn_raw` → identical `btn_n`/`short_press` timing.
